// File: rtl/daq_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// daq_capture_ctrl_if
// Bundles the two AXI-Stream links around the capture controller:
//   s_axis_* : decimated samples arriving from down_sample
//   m_axis_* : packetised samples leaving toward the S2MM DMA
// Modports:
//   master : the capture controller (owns s_axis_tready and all m_axis_* except tready)
//   slave  : the environment (sample source and DMA sink)
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready are
// both high. Once tvalid is raised, tvalid/tdata/tlast stay stable until that
// transfer. The sample side never stalls: s_axis_tready is tied high, so every
// cycle with s_axis_tvalid high delivers a sample.
// -----------------------------------------------------------------------------
interface daq_capture_ctrl_if #(
  parameter int DW = 24
);
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata
  );
endinterface

// File: rtl/daq_capture_ctrl.sv
// -----------------------------------------------------------------------------
// daq_capture_ctrl
// Capture sequencer between the decimation chain and the S2MM DMA. A start
// command arms it, the first cfg_skip samples are discarded (filter settling),
// and the following samples are packed into frames of cfg_frame_len beats with
// tlast on the final beat, for cfg_num_frames frames (0 = until cmd_stop).
// The source is never stalled; samples that find the 1-deep output register
// occupied are dropped and counted.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (master)    s_axis_* sample input, m_axis_* packet output
//   cmd_start       pulse: begin capture (only honoured in IDLE)
//   cmd_stop        pulse: end capture at the next frame boundary
//   cfg_skip        samples discarded after start
//   cfg_frame_len   samples per frame (0 behaves as 1)
//   cfg_num_frames  frames per capture (0 = continuous)
//   busy            capture in progress
//   done            1-cycle pulse when a capture completes or is stopped
//   overflow        sticky: at least one sample dropped in this capture
//   overflow_cnt    dropped-sample count, saturating
//   o_dbg_state     current FSM state (IDLE=0, SKIP=1, RUN=2, FLUSH=3)
// -----------------------------------------------------------------------------
module daq_capture_ctrl #(
  parameter int DW = 24,
  parameter int CW = 16,
  parameter int FW = 16,
  parameter int OW = 16
) (
  input  logic                clk,
  input  logic                rst,
  daq_capture_ctrl_if.master  bus,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic [CW-1:0]       cfg_skip,
  input  logic [CW-1:0]       cfg_frame_len,
  input  logic [FW-1:0]       cfg_num_frames,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [OW-1:0]       overflow_cnt,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_done_set;

  logic [CW-1:0] r_skip;
  logic [CW-1:0] r_len_m1;
  logic [CW-1:0] r_skip_cnt;
  logic [CW-1:0] r_idx;
  logic [FW-1:0] r_num_frames;
  logic [FW-1:0] r_frame_cnt;
  logic          r_stop_pend;
  logic          r_tvalid;
  logic          r_tlast;
  logic [DW-1:0] r_tdata;
  logic          r_done;
  logic          r_ovf;
  logic [OW-1:0] r_ovf_cnt;

  logic w_accept, w_drain, w_room, w_start, w_last_idx, w_frames_done;
  logic w_stop_now, w_load, w_drop, w_end_frame, w_skip_done;

  assign w_accept      = bus.s_axis_tvalid;
  assign w_drain       = r_tvalid && bus.m_axis_tready;
  // The holding register can take a sample if empty or being emptied this edge.
  assign w_room        = !r_tvalid || w_drain;
  // A simultaneous stop cancels the start.
  assign w_start       = cmd_start && !cmd_stop;
  assign w_last_idx    = (r_idx == r_len_m1);
  assign w_frames_done = (r_num_frames != '0) && (r_frame_cnt == r_num_frames - 1'b1);
  // Stop between frames with nothing outstanding: there is no frame to finish.
  assign w_stop_now    = (r_state == ST_RUN) && cmd_stop && (r_idx == '0) && !r_tvalid;
  assign w_load        = (r_state == ST_RUN) && w_accept && w_room && !w_stop_now;
  assign w_drop        = (r_state == ST_RUN) && w_accept && !w_room;
  // A stop arriving on the very cycle the final beat loads still ends this frame.
  assign w_end_frame   = w_load && w_last_idx && (w_frames_done || r_stop_pend || cmd_stop);
  assign w_skip_done   = (r_state == ST_SKIP) && w_accept && (r_skip_cnt == r_skip - 1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = (cfg_skip != '0) ? ST_SKIP : ST_RUN;
      end
      ST_SKIP: begin
        if (cmd_stop) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else if (w_skip_done) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_stop_now) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else if (w_end_frame) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // The held sample in FLUSH is always the closing tlast beat.
        if (w_drain && r_tlast) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy              = (r_state != ST_IDLE);
    done              = r_done;
    overflow          = r_ovf;
    overflow_cnt      = r_ovf_cnt;
    o_dbg_state       = r_state;
    bus.s_axis_tready = 1'b1;
    bus.m_axis_tvalid = r_tvalid;
    bus.m_axis_tlast  = r_tlast;
    bus.m_axis_tdata  = r_tdata;
  end

  // Datapath, counters and holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip       <= '0;
      r_len_m1     <= '0;
      r_skip_cnt   <= '0;
      r_idx        <= '0;
      r_num_frames <= '0;
      r_frame_cnt  <= '0;
      r_stop_pend  <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_ovf_cnt    <= '0;
    end else begin
      r_done <= w_done_set;

      if ((r_state == ST_IDLE) && w_start) begin
        r_skip       <= cfg_skip;
        r_len_m1     <= (cfg_frame_len == '0) ? '0 : cfg_frame_len - 1'b1;
        r_num_frames <= cfg_num_frames;
        r_skip_cnt   <= '0;
        r_idx        <= '0;
        r_frame_cnt  <= '0;
        r_stop_pend  <= 1'b0;
        r_ovf        <= 1'b0;
        r_ovf_cnt    <= '0;
      end

      if ((r_state == ST_SKIP) && w_accept) r_skip_cnt <= r_skip_cnt + 1'b1;

      if ((r_state == ST_RUN) && cmd_stop && !w_stop_now) r_stop_pend <= 1'b1;

      if (w_load) begin
        r_tdata <= bus.s_axis_tdata;
        r_tlast <= w_last_idx;
        if (w_last_idx) begin
          r_idx       <= '0;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end

      if (w_load)       r_tvalid <= 1'b1;
      else if (w_drain) r_tvalid <= 1'b0;

      // Drops leave r_idx untouched so frames stay exactly frame_len beats.
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
    end
  end

endmodule
